// File: rtl/fetch_queue_pkg.sv
// Shared fetch/decode types and the default fetch queue sizing.
// Fetch and decode both import this so their queue depth assumptions agree.
package fetch_queue_pkg;

    localparam int unsigned FETCH_XLEN        = 32;
    localparam int unsigned FETCH_QUEUE_DEPTH = 4;

    typedef logic [FETCH_XLEN-1:0] Addr;
    typedef logic [31:0]           Inst;

    typedef struct packed {
        Addr pc;
        Inst inst;
    } FetchEntry;

endpackage

// File: rtl/fetch_queue_if.sv
// Handshake bundle between the fetch response path, the fetch queue and decode.
// The slave modport is the queue; the master modport is the surrounding pipeline.
interface fetch_queue_if
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = FETCH_QUEUE_DEPTH,
    parameter int unsigned XLEN  = FETCH_XLEN
);

    logic                       flush;
    logic                       in_valid;
    logic                       in_ready;
    logic [XLEN-1:0]            in_pc;
    logic [XLEN-1:0]            in_inst;
    logic                       out_valid;
    logic                       out_ready;
    logic [XLEN-1:0]            out_pc;
    logic [XLEN-1:0]            out_inst;
    logic [$clog2(DEPTH):0]     count;

    modport slave (
        input  flush,
        input  in_valid,
        output in_ready,
        input  in_pc,
        input  in_inst,
        output out_valid,
        input  out_ready,
        output out_pc,
        output out_inst,
        output count
    );

    modport master (
        output flush,
        output in_valid,
        input  in_ready,
        output in_pc,
        output in_inst,
        input  out_valid,
        output out_ready,
        input  out_pc,
        input  out_inst,
        input  count
    );

endinterface

// File: rtl/fetch_queue.sv
// In-order instruction fetch queue: circular buffer of (pc, inst) pairs with flush.
// Define FETCH_QUEUE_BYPASS_EN to present input combinationally when the queue is empty.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = FETCH_QUEUE_DEPTH,
    parameter int unsigned XLEN  = FETCH_XLEN
) (
    input  logic         clk,
    input  logic         reset,
    fetch_queue_if.slave bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } entry_t;

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               empty;
    logic               bypass;
    logic               push;
    logic               pop;
    entry_t             head;

    assign empty = (count_q == '0);

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = empty && bus.in_valid && !bus.flush;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed pair that decode takes this cycle never touches storage.
    assign push = bus.in_valid && (count_q != FULL) && !bus.flush
                  && !(bypass && bus.out_ready);
    assign pop  = !empty && bus.out_ready && !bus.flush;

    always_comb begin
        head = '0;
        if (bypass) begin
            head.pc   = bus.in_pc;
            head.inst = bus.in_inst;
        end else if (!empty) begin
            head = mem_q[rd_ptr_q];
        end
    end

    assign bus.in_ready  = (count_q != FULL);
    assign bus.out_valid = !empty || bypass;
    assign bus.out_pc    = head.pc;
    assign bus.out_inst  = head.inst;
    assign bus.count     = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left unreset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{pc: bus.in_pc, inst: bus.in_inst};
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed scoreboard bench for fetch_queue (DEPTH=4, XLEN=32), covering both
// the registered build and the FETCH_QUEUE_BYPASS_EN build.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned XLEN  = 32;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    FetchEntry exp_q[$];

    fetch_queue_if #(.DEPTH(DEPTH), .XLEN(XLEN)) bus ();

    fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, check outputs against the model before the edge, then advance.
    task automatic cycle(input logic iv, input logic [31:0] pc, input logic [31:0] inst,
                         input logic ordy, input logic fl);
        logic      byp;
        logic      acc;
        logic      pop;
        FetchEntry head;
        bus.in_valid  = iv;
        bus.in_pc     = pc;
        bus.in_inst   = inst;
        bus.out_ready = ordy;
        bus.flush     = fl;
        #1;
        byp = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
        byp = (exp_q.size() == 0) && iv && !fl;
`endif
        if (byp) head = '{pc: pc, inst: inst};
        else if (exp_q.size() != 0) head = exp_q[0];
        else head = '0;
        check("in_ready", 64'(bus.in_ready), 64'(exp_q.size() != DEPTH));
        check("count", 64'(bus.count), 64'(exp_q.size()));
        check("out_valid", 64'(bus.out_valid), 64'((exp_q.size() != 0) || byp));
        check("out_pc", 64'(bus.out_pc), 64'(head.pc));
        check("out_inst", 64'(bus.out_inst), 64'(head.inst));
        pop = (exp_q.size() != 0) && ordy && !fl;
        acc = iv && (exp_q.size() != DEPTH) && !fl && !(byp && ordy);
        if (fl) begin
            exp_q.delete();
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (acc) exp_q.push_back('{pc: pc, inst: inst});
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return {pc[24:0], 7'h13} ^ 32'h5A00_0000;
    endfunction

    initial begin
        vectors       = 0;
        miscompares   = 0;
        reset         = 1'b1;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_pc     = '0;
        bus.in_inst   = '0;
        bus.out_ready = 1'b0;

        // Reset state while reset is held.
        #1;
        check("rst_count", 64'(bus.count), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_pc", 64'(bus.out_pc), 64'd0);
        check("rst_out_inst", 64'(bus.out_inst), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Fill to full, a fifth push is held, then drain in order.
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'(i * 4), NOP, 1'b0, 1'b0);
        cycle(1'b1, 32'h10, NOP, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Refill, then push/pop at full; 0x10 lands after the write pointer wraps.
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'(i * 4), inst_of(32'(i * 4)), 1'b0, 1'b0);
        cycle(1'b1, 32'h10, inst_of(32'h10), 1'b1, 1'b0);
        cycle(1'b1, 32'h10, inst_of(32'h10), 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Flush with concurrent push and pop at count=3.
        cycle(1'b1, 32'h14, inst_of(32'h14), 1'b0, 1'b0);
        cycle(1'b1, 32'h18, inst_of(32'h18), 1'b0, 1'b0);
        cycle(1'b1, 32'h1C, inst_of(32'h1C), 1'b0, 1'b0);
        cycle(1'b1, 32'h20, inst_of(32'h20), 1'b1, 1'b1);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        cycle(1'b1, 32'h24, inst_of(32'h24), 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset between edges with two entries queued.
        cycle(1'b1, 32'h30, inst_of(32'h30), 1'b0, 1'b0);
        cycle(1'b1, 32'h34, inst_of(32'h34), 1'b0, 1'b0);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        #2;
        check("pre_areset_out_valid", 64'(bus.out_valid), 64'd1);
        reset = 1'b1;
        #1;
        check("areset_out_valid", 64'(bus.out_valid), 64'd0);
        check("areset_count", 64'(bus.count), 64'd0);
        check("areset_in_ready", 64'(bus.in_ready), 64'd1);
        check("areset_out_pc", 64'(bus.out_pc), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        cycle(1'b1, 32'h100, inst_of(32'h100), 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Empty-queue push with decode ready, then with decode stalled.
        cycle(1'b1, 32'h40, inst_of(32'h40), 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        cycle(1'b1, 32'h44, inst_of(32'h44), 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
